// File: rtl/sort_three_floats_stream.sv
// ---------------------------------------------------------------------------
// sort_three_floats_stream
//
// Purpose:
//   Streaming three-value FP64 sorter. Values arrive one per upstream
//   valid/ready handshake and are collected into groups of three. Each
//   group is sorted in increasing order by three compare/exchange passes,
//   (0,1), (1,2), (0,1), all sharing a single f_less_or_equal comparator.
//   The sorted group is then emitted one value per downstream handshake.
//   Collection and emission never overlap.
//
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   up_valid    upstream value available
//   up_data     upstream FP64 value
//   up_ready    block accepts up_data this cycle (only while collecting)
//   down_valid  sorted value available
//   down_data   sorted FP64 value (0 when down_valid=0)
//   down_last   third (largest) value of the group
//   down_err    comparator flagged an error while sorting this group
//   down_ready  downstream accepts the value
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// f_less_or_equal
//
// Purpose:
//   Combinational FP64 a <= b compare with signaling-NaN semantics: any NaN
//   operand gives res=0 and err=1. +0.0 and -0.0 compare equal.
//
// Ports:
//   a, b  FP64 operands
//   res   1 when a <= b
//   err   1 when either operand is a NaN
// ---------------------------------------------------------------------------
module f_less_or_equal (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        res,
  output logic        err
);

  logic [62:0] a_mag;
  logic [62:0] b_mag;
  logic        a_nan;
  logic        b_nan;
  logic        both_zero;

  assign a_mag     = a[62:0];
  assign b_mag     = b[62:0];
  assign a_nan     = (&a[62:52]) && (|a[51:0]);
  assign b_nan     = (&b[62:52]) && (|b[51:0]);
  assign both_zero = (~|a_mag) && (~|b_mag);

  always_comb begin
    err = a_nan || b_nan;
    res = 1'b0;
    if (a_nan || b_nan) begin
      res = 1'b0;
    end else if (both_zero) begin
      // Signed zeros are equal regardless of sign bits.
      res = 1'b1;
    end else if (a[63] != b[63]) begin
      // Differing signs: a <= b exactly when a is the negative one.
      res = a[63];
    end else if (!a[63]) begin
      res = (a_mag <= b_mag);
    end else begin
      // Both negative: larger magnitude is the smaller value.
      res = (a_mag >= b_mag);
    end
  end

endmodule

module sort_three_floats_stream (
  input  logic        clk,
  input  logic        rst,
  input  logic        up_valid,
  input  logic [63:0] up_data,
  output logic        up_ready,
  output logic        down_valid,
  output logic [63:0] down_data,
  output logic        down_last,
  output logic        down_err,
  input  logic        down_ready
);

  localparam int FLEN = 64;

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    CMP01   = 3'd1,
    CMP12   = 3'd2,
    CMP01B  = 3'd3,
    EMIT    = 3'd4
  } state_t;

  state_t                   state_reg, state_next;
  logic [1:0]               in_cnt_reg, in_cnt_next;
  logic [1:0]               out_idx_reg, out_idx_next;
  logic                     err_acc_reg, err_acc_next;
  logic [2:0][FLEN-1:0]     data_buf_reg;
  logic [2:0][FLEN-1:0]     data_buf_next;

  // Control decoded by the FSM for the datapath.
  logic                     load_en;
  logic [1:0]               pair_swap;   // [0]: exchange entries 0/1, [1]: entries 1/2

  // Shared comparator.
  logic [FLEN-1:0]          cmp_a;
  logic [FLEN-1:0]          cmp_b;
  logic                     cmp_res;
  logic                     cmp_err;

  // CMP12 is the only pass that looks at the upper pair.
  assign cmp_a = (state_reg == CMP12) ? data_buf_reg[1] : data_buf_reg[0];
  assign cmp_b = (state_reg == CMP12) ? data_buf_reg[2] : data_buf_reg[1];

  f_less_or_equal u_cmp (
    .a   (cmp_a),
    .b   (cmp_b),
    .res (cmp_res),
    .err (cmp_err)
  );

  // -------------------------------------------------------------------------
  // FSM: next state, counters and datapath controls
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    in_cnt_next  = in_cnt_reg;
    out_idx_next = out_idx_reg;
    err_acc_next = err_acc_reg;
    load_en      = 1'b0;
    pair_swap    = 2'b00;

    case (state_reg)
      COLLECT: begin
        if (up_valid) begin
          load_en = 1'b1;
          if (in_cnt_reg == 2'd2) begin
            in_cnt_next  = 2'd0;
            err_acc_next = 1'b0;
            state_next   = CMP01;
          end else begin
            in_cnt_next = in_cnt_reg + 2'd1;
          end
        end
      end
      // Swap only when a > b (res=0) so equal values keep arrival order.
      CMP01: begin
        pair_swap[0] = !cmp_res;
        err_acc_next = err_acc_reg | cmp_err;
        state_next   = CMP12;
      end
      CMP12: begin
        pair_swap[1] = !cmp_res;
        err_acc_next = err_acc_reg | cmp_err;
        state_next   = CMP01B;
      end
      CMP01B: begin
        pair_swap[0] = !cmp_res;
        err_acc_next = err_acc_reg | cmp_err;
        state_next   = EMIT;
      end
      EMIT: begin
        if (down_ready) begin
          if (out_idx_reg == 2'd2) begin
            out_idx_next = 2'd0;
            state_next   = COLLECT;
          end else begin
            out_idx_next = out_idx_reg + 2'd1;
          end
        end
      end
      default: begin
        state_next = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= COLLECT;
      in_cnt_reg  <= 2'd0;
      out_idx_reg <= 2'd0;
      err_acc_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      in_cnt_reg  <= in_cnt_next;
      out_idx_reg <= out_idx_next;
      err_acc_reg <= err_acc_next;
    end
  end

  // -------------------------------------------------------------------------
  // Value buffer: each entry either loads upstream data, takes a neighbour
  // during a compare/exchange, or holds. Contents are don't-care after reset,
  // so the buffer itself is not reset.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_buf
      logic [FLEN-1:0] swapped_val;

      if (gi == 0) begin : g_lo
        assign swapped_val = pair_swap[0] ? data_buf_reg[1] : data_buf_reg[0];
      end else if (gi == 1) begin : g_mid
        assign swapped_val = pair_swap[0] ? data_buf_reg[0] :
                             pair_swap[1] ? data_buf_reg[2] : data_buf_reg[1];
      end else begin : g_hi
        assign swapped_val = pair_swap[1] ? data_buf_reg[1] : data_buf_reg[2];
      end

      assign data_buf_next[gi] = (load_en && (in_cnt_reg == 2'(gi))) ? up_data
                                                                      : swapped_val;

      always_ff @(posedge clk) begin
        data_buf_reg[gi] <= data_buf_next[gi];
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Outputs. Gated with rst so the reset cycle itself presents an idle port.
  // -------------------------------------------------------------------------
  assign up_ready   = (state_reg == COLLECT) && !rst;
  assign down_valid = (state_reg == EMIT) && !rst;
  assign down_last  = down_valid && (out_idx_reg == 2'd2);
  assign down_err   = down_valid && err_acc_reg;

  always_comb begin
    down_data = '0;
    if (down_valid) begin
      case (out_idx_reg)
        2'd0:    down_data = data_buf_reg[0];
        2'd1:    down_data = data_buf_reg[1];
        default: down_data = data_buf_reg[2];
      endcase
    end
  end

endmodule
